scgra_io_buffer: RTL and testbench
==================================

Name: scgra_io_buffer

Overview:
- Host-side load/store buffer for the SCGRA IO processing element.
- It sources the PE_Load stream into the PE array and captures the PE_Store stream back into a local buffer.
- It runs a start/done FSM that drives PE_Array_Busy for the compute window.
- The host fills and drains the buffer only while the array is idle.

Parameters:
DWIDTH, 32, data word width
AWIDTH, 10, buffer address width (depth = 2^AWIDTH words)
CWIDTH, 16, width of the cycle counter and length/delay config fields

Ports:
Clk  input  1  clock
Reset  input  1  synchronous, active-high reset
Start  input  1  one-cycle run request; only accepted in IDLE
Run_Len  input  CWIDTH  compute window length in cycles
Load_Base  input  AWIDTH  first buffer address streamed to PE_Load
Load_Len  input  CWIDTH  number of words streamed to PE_Load
Store_Base  input  AWIDTH  first buffer address written from PE_Store
Store_Len  input  CWIDTH  number of PE_Store words captured
Store_Delay  input  CWIDTH  run cycle index of the first valid PE_Store
PE_Load  output  DWIDTH  load word to the IO PE
PE_Store  input  DWIDTH  store word from the IO PE
PE_Array_Busy  output  1  high for the whole compute window
Done  output  1  one-cycle pulse when the run completes
Host_Ready  output  1  high when host access is permitted (IDLE)
Host_We  input  1  host write strobe
Host_Re  input  1  host read strobe
Host_Addr  input  AWIDTH  host address
Host_Wdata  input  DWIDTH  host write data
Host_Rdata  output  DWIDTH  host read data
Host_Rvalid  output  1  Host_Rdata valid

Behaviour:
- Reset values:
  - FSM returns to IDLE.
  - PE_Load=0, PE_Array_Busy=0, Done=0, Host_Rdata=0, Host_Rvalid=0, Host_Ready=1.
  - Buffer contents are not cleared.
  - Reset mid-run abandons the run immediately, with no Done pulse.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - Host_Ready=1.
  - Host_We writes Host_Wdata to mem[Host_Addr].
  - Host_Re returns mem[Host_Addr] on Host_Rdata with Host_Rvalid=1 on the next cycle; otherwise Host_Rvalid=0.
  - Host_We and Host_Re together at the same address: the read returns the old data.
- Start in IDLE:
  - Latches all config inputs and clears the cycle counter Cyc to 0.
  - Run_Len != 0: next state RUN, PE_Array_Busy=1 from the next cycle.
  - Run_Len == 0: next state FINISH directly.
  - A host write in the same cycle as Start completes and is visible to the run.
  - Start outside IDLE is ignored.
- RUN, each cycle with counter Cyc:
  - Load: if Cyc < Load_Len, read mem[(Load_Base+Cyc) mod 2^AWIDTH]. PE_Load presents that word on the following cycle (1-cycle latency); otherwise PE_Load=0 on the following cycle.
  - Store: if Cyc >= Store_Delay and (Cyc-Store_Delay) < Store_Len, write PE_Store to mem[(Store_Base+Cyc-Store_Delay) mod 2^AWIDTH].
  - Load and store hitting the same address in the same cycle: read-first, so PE_Load carries the old word.
  - Host_We/Host_Re are ignored and Host_Ready=0.
  - Cyc increments; when Cyc == Run_Len-1, next state is FINISH.
  - Store or load windows extending past Run_Len are truncated.
- FINISH:
  - One cycle with Done=1 and PE_Array_Busy=0.
  - PE_Load shows the final loaded word or 0 per the RUN rule, then returns to 0.
  - Next state is IDLE.
- Address arithmetic wraps modulo 2^AWIDTH.
- Counter comparisons are unsigned at CWIDTH bits.
- The buffer is a single dual-port memory:
  - port A serves host/load reads;
  - port B serves host/store writes.

Test Plan:
- Host fill/readback: write mem[5]=0xDEADBEEF, then Host_Re addr 5 → next cycle Host_Rdata=0xDEADBEEF, Host_Rvalid=1, Host_Ready=1.
- Load stream: mem[10..13]=1,2,3,4; Start with Load_Base=10, Load_Len=4, Run_Len=6 → PE_Load=1,2,3,4,0 on the cycles after RUN cycles 0..4. PE_Array_Busy high 6 cycles, then Done pulses once.
- Store capture: Store_Base=100, Store_Delay=3, Store_Len=2, PE_Store=0xA0+Cyc → after Done, host reads mem[100]=0xA3 and mem[101]=0xA4; mem[102] unchanged.
- Wrap and collision: Load_Base=1023, Load_Len=2 → reads addr 1023 then 0. Also Store_Base=Load_Base with Store_Delay=0 → PE_Load shows the pre-run word and the new word is readable afterwards.
- Boundaries:
  - Run_Len=0 → Done the cycle after Start, with Busy never high.
  - Start during RUN → ignored, Done exactly once.
  - Host_We during RUN → memory unchanged.
- Reset mid-run: assert Reset at RUN cycle 2 → next cycle IDLE, Busy=0, PE_Load=0, no Done. Stored words already written stay; a new Start runs normally.

Source files
------------

// File: rtl/scgra_io_buffer.sv
// Host-side load/store buffer for the SCGRA IO PE: streams PE_Load, captures PE_Store,
// and frames the compute window with a start/done FSM. Host access only while idle.
module scgra_io_buffer #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 10,
    parameter int unsigned CWIDTH = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [CWIDTH-1:0] Run_Len,
    input  logic [AWIDTH-1:0] Load_Base,
    input  logic [CWIDTH-1:0] Load_Len,
    input  logic [AWIDTH-1:0] Store_Base,
    input  logic [CWIDTH-1:0] Store_Len,
    input  logic [CWIDTH-1:0] Store_Delay,
    output logic [DWIDTH-1:0] PE_Load,
    input  logic [DWIDTH-1:0] PE_Store,
    output logic              PE_Array_Busy,
    output logic              Done,
    output logic              Host_Ready,
    input  logic              Host_We,
    input  logic              Host_Re,
    input  logic [AWIDTH-1:0] Host_Addr,
    input  logic [DWIDTH-1:0] Host_Wdata,
    output logic [DWIDTH-1:0] Host_Rdata,
    output logic              Host_Rvalid
);

    localparam int unsigned DEPTH = 1 << AWIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t state, state_n;

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [CWIDTH-1:0] cyc;
    logic [CWIDTH-1:0] run_len_q, load_len_q, store_len_q, store_delay_q;
    logic [AWIDTH-1:0] load_base_q, store_base_q;

    logic              start_ok;
    logic              load_en, store_en, host_we_en, host_re_en;
    logic [CWIDTH-1:0] store_idx;
    logic [AWIDTH-1:0] rd_addr, wr_addr;
    logic [DWIDTH-1:0] wr_data;
    logic              wr_en;

    logic [DWIDTH-1:0] pe_load_n, host_rdata_n;
    logic              busy_n, done_n, ready_n, host_rvalid_n;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (Start) state_n = (Run_Len != '0) ? RUN : FINISH;
            RUN:     if (cyc == run_len_q - CWIDTH'(1)) state_n = FINISH;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath enables and memory port muxing
    always_comb begin
        start_ok   = (state == IDLE) && Start;
        host_we_en = (state == IDLE) && Host_We;
        host_re_en = (state == IDLE) && Host_Re;
        load_en    = (state == RUN) && (cyc < load_len_q);
        store_idx  = cyc - store_delay_q;
        store_en   = (state == RUN) && (cyc >= store_delay_q) && (store_idx < store_len_q);
        rd_addr    = (state == RUN) ? load_base_q + AWIDTH'(cyc) : Host_Addr;
        wr_addr    = (state == RUN) ? store_base_q + AWIDTH'(store_idx) : Host_Addr;
        wr_data    = (state == RUN) ? PE_Store : Host_Wdata;
        wr_en      = !Reset && (store_en || host_we_en);
    end

    // Output next values
    always_comb begin
        busy_n        = (state_n == RUN);
        done_n        = (state_n == FINISH);
        ready_n       = (state_n == IDLE);
        host_rvalid_n = host_re_en;
        pe_load_n     = load_en ? mem[rd_addr] : '0;
        host_rdata_n  = host_re_en ? mem[rd_addr] : Host_Rdata;
    end

    // Output registers; reads sample the array before this edge's write (read-first)
    always_ff @(posedge Clk) begin
        if (Reset) begin
            PE_Load       <= '0;
            PE_Array_Busy <= 1'b0;
            Done          <= 1'b0;
            Host_Ready    <= 1'b1;
            Host_Rdata    <= '0;
            Host_Rvalid   <= 1'b0;
        end else begin
            PE_Load       <= pe_load_n;
            PE_Array_Busy <= busy_n;
            Done          <= done_n;
            Host_Ready    <= ready_n;
            Host_Rdata    <= host_rdata_n;
            Host_Rvalid   <= host_rvalid_n;
        end
    end

    // Buffer write port; contents survive reset
    always_ff @(posedge Clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Run configuration latched on an accepted Start
    always_ff @(posedge Clk) begin
        if (start_ok) begin
            run_len_q     <= Run_Len;
            load_base_q   <= Load_Base;
            load_len_q    <= Load_Len;
            store_base_q  <= Store_Base;
            store_len_q   <= Store_Len;
            store_delay_q <= Store_Delay;
        end
    end

    // Run cycle counter
    always_ff @(posedge Clk) begin
        if (Reset)               cyc <= '0;
        else if (start_ok)       cyc <= '0;
        else if (state == RUN)   cyc <= cyc + CWIDTH'(1);
    end

endmodule

// File: tb/tb_scgra_io_buffer.sv
// Directed bench for scgra_io_buffer: host access, load/store streaming, wrap,
// collision, zero-length run, ignored requests and mid-run reset.
module tb_scgra_io_buffer;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 10;
    localparam int unsigned CW = 16;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic [CW-1:0] Run_Len = '0, Load_Len = '0, Store_Len = '0, Store_Delay = '0;
    logic [AW-1:0] Load_Base = '0, Store_Base = '0, Host_Addr = '0;
    logic [DW-1:0] PE_Load, PE_Store = '0, Host_Wdata = '0, Host_Rdata;
    logic          PE_Array_Busy, Done, Host_Ready, Host_Rvalid;
    logic          Host_We = 1'b0, Host_Re = 1'b0;

    int total = 0;
    int bad = 0;

    scgra_io_buffer #(.DWIDTH(DW), .AWIDTH(AW), .CWIDTH(CW)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Run_Len(Run_Len),
        .Load_Base(Load_Base), .Load_Len(Load_Len), .Store_Base(Store_Base),
        .Store_Len(Store_Len), .Store_Delay(Store_Delay), .PE_Load(PE_Load),
        .PE_Store(PE_Store), .PE_Array_Busy(PE_Array_Busy), .Done(Done),
        .Host_Ready(Host_Ready), .Host_We(Host_We), .Host_Re(Host_Re),
        .Host_Addr(Host_Addr), .Host_Wdata(Host_Wdata), .Host_Rdata(Host_Rdata),
        .Host_Rvalid(Host_Rvalid)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        Host_We = 1'b1; Host_Addr = a; Host_Wdata = d;
        tick();
        Host_We = 1'b0;
    endtask

    task automatic host_read_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        Host_Re = 1'b1; Host_Addr = a;
        tick();
        Host_Re = 1'b0;
        check({tag, "_rvalid"}, DW'(Host_Rvalid), 32'd1);
        check(tag, Host_Rdata, exp);
    endtask

    task automatic start_run(input logic [CW-1:0] rl, input logic [AW-1:0] lb, input logic [CW-1:0] ll,
                             input logic [AW-1:0] sb, input logic [CW-1:0] sl, input logic [CW-1:0] sd);
        Start = 1'b1; Run_Len = rl; Load_Base = lb; Load_Len = ll;
        Store_Base = sb; Store_Len = sl; Store_Delay = sd;
        tick();
        Start = 1'b0;
    endtask

    logic [DW-1:0] load_exp [6];

    initial begin
        load_exp[0] = 32'd1; load_exp[1] = 32'd2; load_exp[2] = 32'd3;
        load_exp[3] = 32'd4; load_exp[4] = 32'd0; load_exp[5] = 32'd0;

        tick(); tick();
        check("rst_pe_load", PE_Load, 32'd0);
        check("rst_busy", DW'(PE_Array_Busy), 32'd0);
        check("rst_done", DW'(Done), 32'd0);
        check("rst_rdata", Host_Rdata, 32'd0);
        check("rst_rvalid", DW'(Host_Rvalid), 32'd0);
        check("rst_ready", DW'(Host_Ready), 32'd1);
        Reset = 1'b0;
        tick();

        // Host fill and readback
        host_write(10'd5, 32'hDEADBEEF);
        host_read_check("rd5", 10'd5, 32'hDEADBEEF);
        check("rd5_ready", DW'(Host_Ready), 32'd1);
        tick();
        check("rvalid_drop", DW'(Host_Rvalid), 32'd0);
        // Simultaneous write and read return the old word
        Host_We = 1'b1; Host_Re = 1'b1; Host_Addr = 10'd5; Host_Wdata = 32'h12345678;
        tick();
        Host_We = 1'b0; Host_Re = 1'b0;
        check("wr_rd_same_old", Host_Rdata, 32'hDEADBEEF);
        host_read_check("rd5_new", 10'd5, 32'h12345678);

        // Load stream + store capture + ignored Start/Host_We during RUN
        host_write(10'd10, 32'd1);
        host_write(10'd11, 32'd2);
        host_write(10'd12, 32'd3);
        host_write(10'd13, 32'd4);
        host_write(10'd102, 32'h55);
        start_run(16'd6, 10'd10, 16'd4, 10'd100, 16'd2, 16'd3);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("run_busy_%0d", k), DW'(PE_Array_Busy), 32'd1);
            check($sformatf("run_done_%0d", k), DW'(Done), 32'd0);
            check($sformatf("run_ready_%0d", k), DW'(Host_Ready), 32'd0);
            PE_Store = 32'hA0 + DW'(k);
            if (k == 1) begin Host_We = 1'b1; Host_Addr = 10'd12; Host_Wdata = 32'hBAD; end
            if (k == 2) begin Start = 1'b1; Run_Len = 16'd0; end
            tick();
            Host_We = 1'b0; Start = 1'b0;
            check($sformatf("pe_load_%0d", k), PE_Load, load_exp[k]);
        end
        check("fin_done", DW'(Done), 32'd1);
        check("fin_busy", DW'(PE_Array_Busy), 32'd0);
        tick();
        check("post_done", DW'(Done), 32'd0);
        check("post_ready", DW'(Host_Ready), 32'd1);
        check("post_pe_load", PE_Load, 32'd0);
        tick();
        check("post_done2", DW'(Done), 32'd0);
        host_read_check("st100", 10'd100, 32'hA3);
        host_read_check("st101", 10'd101, 32'hA4);
        host_read_check("st102", 10'd102, 32'h55);
        host_read_check("run_we_ignored", 10'd12, 32'd3);

        // Address wrap and same-address load/store collision
        host_write(10'd1023, 32'h11);
        host_write(10'd0, 32'h22);
        PE_Store = 32'h77;
        start_run(16'd2, 10'd1023, 16'd2, 10'd1023, 16'd1, 16'd0);
        tick();
        check("wrap_load0", PE_Load, 32'h11);
        PE_Store = 32'h88;
        tick();
        check("wrap_load1", PE_Load, 32'h22);
        check("wrap_done", DW'(Done), 32'd1);
        tick();
        host_read_check("coll_new", 10'd1023, 32'h77);
        host_read_check("wrap_addr0", 10'd0, 32'h22);

        // Zero-length run
        start_run(16'd0, 10'd10, 16'd4, 10'd300, 16'd4, 16'd0);
        check("zero_done", DW'(Done), 32'd1);
        check("zero_busy", DW'(PE_Array_Busy), 32'd0);
        check("zero_pe_load", PE_Load, 32'd0);
        tick();
        check("zero_done_end", DW'(Done), 32'd0);
        check("zero_ready", DW'(Host_Ready), 32'd1);

        // Reset during RUN cycle 2
        host_write(10'd202, 32'h99);
        start_run(16'd10, 10'd10, 16'd4, 10'd200, 16'd5, 16'd0);
        PE_Store = 32'hC0;
        tick();
        PE_Store = 32'hC1;
        tick();
        PE_Store = 32'hC2;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("mr_busy", DW'(PE_Array_Busy), 32'd0);
        check("mr_pe_load", PE_Load, 32'd0);
        check("mr_done", DW'(Done), 32'd0);
        check("mr_ready", DW'(Host_Ready), 32'd1);
        tick();
        check("mr_done_later", DW'(Done), 32'd0);
        host_read_check("mr_st200", 10'd200, 32'hC0);
        host_read_check("mr_st201", 10'd201, 32'hC1);
        host_read_check("mr_st202", 10'd202, 32'h99);
        start_run(16'd1, 10'd10, 16'd1, 10'd400, 16'd0, 16'd0);
        check("rerun_busy", DW'(PE_Array_Busy), 32'd1);
        tick();
        check("rerun_load", PE_Load, 32'd1);
        check("rerun_done", DW'(Done), 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
